// File: rtl/beinmotion_pb_pkg.sv
// Shared constants for the BeInMotion push-button controller: register map and
// default parameter values.
package beinmotion_pb_pkg;

  localparam logic [1:0] PB_ADDR_DATA = 2'd0;
  localparam logic [1:0] PB_ADDR_MASK = 2'd1;
  localparam logic [1:0] PB_ADDR_EDGE = 2'd2;
  localparam logic [1:0] PB_ADDR_RAW  = 2'd3;

  localparam int PB_WIDTH_DEFAULT    = 7;
  localparam int PB_DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/beinmotion_pb_debounce.sv
// One push-button bit: 2-flop synchronizer, stability counter and stable level.
// The counter exists only when BEINMOTION_PB_DEBOUNCE_EN is defined.
module beinmotion_pb_debounce
  import beinmotion_pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_sync,
  output logic o_stable,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_stable;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

`ifdef BEINMOTION_PB_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  // The level is accepted on the sample that completes the stable run.
  assign w_expire = (r_sync != r_stable) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync == r_stable) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_stable <= r_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_rise = w_expire & r_sync;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES > 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable <= 1'b0;
    else          r_stable <= r_sync;
  end

  assign o_rise = r_sync & ~r_stable;
`endif

  assign o_sync   = r_sync;
  assign o_stable = r_stable;

endmodule

// File: rtl/beinmotion_pb_ctrl.sv
// Avalon-MM push-button controller: debounced levels, IRQ mask, W1C edge capture
// and raw levels. Debounce counters are built when BEINMOTION_PB_DEBOUNCE_EN is defined.
module beinmotion_pb_ctrl
  import beinmotion_pb_pkg::*;
#(
  parameter int WIDTH           = PB_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_edge_clr;
  logic             w_mask_we;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    beinmotion_pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (in_port[gi]),
      .o_sync  (w_sync[gi]),
      .o_stable(w_stable[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  assign w_mask_we      = write && (address == PB_ADDR_MASK);
  assign w_edge_clr     = (write && (address == PB_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = &{1'b0, writedata};

  // A rise arriving with a clear of the same bit keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
      irq    <= 1'b0;
    end else begin
      if (w_mask_we) r_mask <= writedata[WIDTH-1:0];
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      irq    <= |(r_edge & r_mask);
    end
  end

  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; a path that leaves w_rdata unassigned would infer a latch.
  always_comb begin
    w_rdata = '0;
    case (address)
      PB_ADDR_DATA: w_rdata = 32'(w_stable);
      PB_ADDR_MASK: w_rdata = 32'(r_mask);
      PB_ADDR_EDGE: w_rdata = 32'(r_edge);
      PB_ADDR_RAW:  w_rdata = 32'(w_sync);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

endmodule

// File: tb/tb_beinmotion_pb_ctrl.sv
// Directed bench for beinmotion_pb_ctrl (WIDTH=7, DEBOUNCE_CYCLES=4); expected
// latencies follow BEINMOTION_PB_DEBOUNCE_EN as seen by this file.
module tb_beinmotion_pb_ctrl;
  import beinmotion_pb_pkg::*;

  localparam int WIDTH = 7;
  localparam int DEB   = 4;
`ifdef BEINMOTION_PB_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam logic [11:0] PAT = 12'b0110_1001_1101;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             write;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  beinmotion_pb_ctrl #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .in_port  (in_port),
    .readdata (readdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    writedata = '0;
  endtask

  // Drives PAT on in_port[4] one bit per cycle and records readdata[4].
  task automatic run_pattern(input logic [1:0] a, output logic [11:0] obs);
    logic [11:0] pat;
    pat        = PAT;
    obs        = '0;
    in_port[4] = 1'b0;
    address    = a;
    repeat (4) tick();
    for (int i = 0; i < 12; i++) begin
      in_port[4] = pat[i];
      tick();
      obs[i] = readdata[4];
    end
    in_port[4] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] obs;
    logic        prev;
    int          n_chg;
    int          chg_at;

    reset_n   = 1'b0;
    address   = PB_ADDR_DATA;
    write     = 1'b0;
    writedata = '0;
    in_port   = 7'h7F;
    repeat (3) tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    // Buttons held through reset release count as fresh presses.
    reset_n = 1'b1;
    repeat (8) tick();
    bus_read(PB_ADDR_DATA, rd); check("held_data", rd, 32'h7F);
    bus_read(PB_ADDR_EDGE, rd); check("held_edge", rd, 32'h7F);
    bus_read(PB_ADDR_RAW, rd);  check("held_raw", rd, 32'h7F);
    check("held_irq_masked", {31'b0, irq}, 32'h0);

    bus_write(PB_ADDR_EDGE, 32'h7F);
    in_port = '0;
    repeat (10) tick();
    bus_read(PB_ADDR_DATA, rd); check("release_data", rd, 32'h0);
    bus_read(PB_ADDR_EDGE, rd); check("release_no_edge", rd, 32'h0);

    bus_write(PB_ADDR_MASK, 32'hFFFF_FFFF);
    bus_read(PB_ADDR_MASK, rd); check("mask_width", rd, 32'h7F);
    bus_write(PB_ADDR_DATA, 32'hFFFF_FFFF);
    bus_write(PB_ADDR_RAW, 32'hFFFF_FFFF);
    bus_read(PB_ADDR_DATA, rd); check("data_ro", rd, 32'h0);
    bus_read(PB_ADDR_MASK, rd); check("mask_after_ro_writes", rd, 32'h7F);
    bus_write(PB_ADDR_MASK, 32'h0);

`ifdef BEINMOTION_PB_DEBOUNCE_EN
    // Two-cycle bounces, then a steady press starting at step 8.
    address = PB_ADDR_DATA;
    tick();
    prev   = readdata[0];
    n_chg  = 0;
    chg_at = -1;
    for (int i = 0; i < 24; i++) begin
      in_port[0] = (i >= 8) || ((i % 4) < 2);
      tick();
      if (readdata[0] !== prev) begin
        n_chg++;
        chg_at = i;
        prev   = readdata[0];
      end
    end
    check("bounce_changes", n_chg, 32'd1);
    check("bounce_change_step", chg_at, 32'(8 + LAT));
    bus_read(PB_ADDR_EDGE, rd); check("bounce_edge", rd, 32'h01);
`else
    bus_write(PB_ADDR_MASK, 32'h08);
    in_port[3] = 1'b1;
    tick();
    in_port[3] = 1'b0;
    tick();
    tick();
    check("pulse_irq_early", {31'b0, irq}, 32'h0);
    tick();
    check("pulse_irq", {31'b0, irq}, 32'h1);
    bus_read(PB_ADDR_EDGE, rd); check("pulse_edge", rd, 32'h08);
    bus_write(PB_ADDR_MASK, 32'h0);
    run_pattern(PB_ADDR_DATA, obs);
    check("data_lag", {20'b0, obs}, {20'b0, PAT << 3});
    run_pattern(PB_ADDR_RAW, obs);
    check("raw_lag", {20'b0, obs}, {20'b0, PAT << 2});
`endif
    bus_write(PB_ADDR_EDGE, 32'h7F);
    in_port = '0;
    repeat (10) tick();
    bus_read(PB_ADDR_DATA, rd); check("idle_data", rd, 32'h0);

    // IRQ path on bit 2.
    bus_write(PB_ADDR_MASK, 32'h04);
    in_port[2] = 1'b1;
    repeat (LAT) tick();
    check("irq_at_edge", {31'b0, irq}, 32'h0);
    tick();
    check("irq_after_edge", {31'b0, irq}, 32'h1);
    bus_write(PB_ADDR_EDGE, 32'h04);
    check("irq_on_clear_edge", {31'b0, irq}, 32'h1);
    tick();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(PB_ADDR_EDGE, rd); check("edge_cleared", rd, 32'h0);

    // Masked edge on bit 5, then unmask.
    bus_write(PB_ADDR_MASK, 32'h0);
    in_port[5] = 1'b1;
    repeat (LAT + 2) tick();
    check("masked_irq", {31'b0, irq}, 32'h0);
    bus_read(PB_ADDR_EDGE, rd); check("masked_edge", rd, 32'h20);
    bus_write(PB_ADDR_MASK, 32'h20);
    check("unmask_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check("unmask_irq", {31'b0, irq}, 32'h1);

    // Clear of bit 1 lands on the same edge as its rise.
    bus_write(PB_ADDR_EDGE, 32'h20);
    bus_write(PB_ADDR_MASK, 32'h02);
    in_port[1] = 1'b1;
    repeat (LAT - 1) tick();
    bus_write(PB_ADDR_EDGE, 32'h02);
    check("collide_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check("collide_irq", {31'b0, irq}, 32'h1);
    bus_read(PB_ADDR_EDGE, rd); check("collide_edge", rd, 32'h02);

    // Reset in the middle of a debounce run.
    in_port[6] = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    in_port = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    bus_read(PB_ADDR_EDGE, rd); check("postreset_edge", rd, 32'h0);
    bus_read(PB_ADDR_DATA, rd); check("postreset_data", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
